systolic_skew_feeder: RTL

- Multi-channel successor to the single-lane transpose FIFO.
- Buffers a CHANNELS x DEPTH operand tile, loaded one row per channel, one row per cycle.
- Drains all channels in parallel with a diagonal skew: channel c starts c cycles after channel 0, which is the wavefront a systolic MAC array expects on its edge.
- Sits between the operand loader and the systolic array's row inputs, and adds valid/ready load, a stall-able drain and a completion pulse.

---
 rtl/systolic_skew_feeder.sv | 116 +++++++++++
 1 files changed

// File: rtl/systolic_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module   : systolic_skew_feeder
// Brief    : Buffers a CHANNELS x DEPTH operand tile row by row, then drains
//            every channel in parallel with a one-cycle-per-channel diagonal
//            skew for the edge of a systolic MAC array.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_skew_feeder #(
    parameter int BITS     = 8,
    parameter int DEPTH    = 8,
    parameter int CHANNELS = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_valid,
    output logic            wr_ready,
    input  logic [BITS-1:0] wr_row   [DEPTH-1:0],
    input  logic            start,
    input  logic            en,
    output logic [BITS-1:0] out_data [CHANNELS-1:0],
    output logic [CHANNELS-1:0] out_vld,
    output logic            busy,
    output logic            done
);

    localparam int c_pw = $clog2(CHANNELS);
    localparam int c_cw = $clog2(DEPTH + CHANNELS);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_full  = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [c_pw-1:0] c_last_ptr = c_pw'(CHANNELS - 1);
    localparam logic [c_cw-1:0] c_last_cnt = c_cw'(DEPTH + CHANNELS - 2);

    logic [1:0]       r_state;
    logic [c_pw-1:0]  r_wr_ptr;
    logic [c_cw-1:0]  r_cnt;
    logic [BITS-1:0]  r_mem [CHANNELS-1:0][DEPTH-1:0];

    logic [CHANNELS-1:0] w_inwin;
    logic [31:0]         w_cnt_ext;
    logic                w_wr_fire;

    assign w_cnt_ext = 32'(r_cnt);
    assign wr_ready  = (r_state == c_st_idle);
    assign busy      = (r_state == c_st_full) || (r_state == c_st_drain);
    assign done      = (r_state == c_st_done);
    assign w_wr_fire = wr_valid && wr_ready;

    // Each channel's head is always mem[c][DEPTH-1]; the window gates it out.
    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign w_inwin[c]  = (r_state == c_st_drain) &&
                             (w_cnt_ext >= 32'(c)) &&
                             (w_cnt_ext <  32'(c + DEPTH));
        assign out_vld[c]  = w_inwin[c] && en;
        assign out_data[c] = w_inwin[c] ? r_mem[c][DEPTH-1] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_wr_ptr <= '0;
            r_cnt    <= '0;
            for (int c = 0; c < CHANNELS; c++)
                for (int k = 0; k < DEPTH; k++)
                    r_mem[c][k] <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_wr_fire) begin
                        for (int k = 0; k < DEPTH; k++)
                            r_mem[r_wr_ptr][k] <= wr_row[k];
                        if (r_wr_ptr == c_last_ptr) begin
                            r_wr_ptr <= '0;
                            r_state  <= c_st_full;
                        end else begin
                            r_wr_ptr <= r_wr_ptr + c_pw'(1);
                        end
                    end
                end
                c_st_full: begin
                    if (start) begin
                        r_state <= c_st_drain;
                        r_cnt   <= '0;
                    end
                end
                c_st_drain: begin
                    if (en) begin
                        if (r_cnt == c_last_cnt) begin
                            r_state <= c_st_done;
                            r_cnt   <= '0;
                            for (int c = 0; c < CHANNELS; c++)
                                for (int k = 0; k < DEPTH; k++)
                                    r_mem[c][k] <= '0;
                        end else begin
                            r_cnt <= r_cnt + c_cw'(1);
                            for (int c = 0; c < CHANNELS; c++) begin
                                if (w_inwin[c]) begin
                                    for (int k = DEPTH - 1; k > 0; k--)
                                        r_mem[c][k] <= r_mem[c][k-1];
                                    r_mem[c][0] <= '0;
                                end
                            end
                        end
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire
